// File: rtl/in_out_handle.sv
// Synthetic raster video source (diagonal test image) plus a
// pixel-capture sink that tags each active pixel with its column/row.
module in_out_handle #(
  parameter int WIDTH   = 16,
  parameter int HEIGHT  = 16,
  parameter int H_BLANK = 2,
  parameter int V_BLANK = 4
) (
  input  logic       Clk,
  input  logic       nReset,
  output logic [7:0] Pixel,
  output logic       Frame,
  output logic       Line,
  output logic [7:0] data,
  output logic [7:0] i,
  output logic [7:0] j
);

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    HBLANK = 2'd1,
    VBLANK = 2'd2
  } state_e;

  localparam logic [7:0]  XMAX   = 8'(WIDTH - 1);
  localparam logic [7:0]  XLAST  = 8'(WIDTH - 2);
  localparam logic [7:0]  YMAX   = 8'(HEIGHT - 1);
  localparam logic [15:0] HMAX   = 16'(H_BLANK - 1);
  localparam logic [15:0] VMAX   = 16'(V_BLANK - 1);
  localparam logic        HB_EN  = (H_BLANK > 0);
  localparam logic        VB_EN  = (V_BLANK > 0);
  localparam logic        COL_EN = (WIDTH > 1);

  state_e      state_q, state_d;
  logic [7:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic [15:0] b_q, b_d;
  logic [7:0]  pix_q, pix_d;
  logic        frm_q, frm_d;
  logic        lin_q, lin_d;
  logic        row_done;

  logic [7:0]  data_q, data_d;
  logic [7:0]  i_q, i_d;
  logic [7:0]  j_q, j_d;
  logic        col_q, col_d;

  // Source registers: position, blank counter and registered strobes.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= ACTIVE;
      x_q     <= '0;
      y_q     <= '0;
      b_q     <= '0;
      pix_q   <= '0;
      frm_q   <= 1'b0;
      lin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      b_q     <= b_d;
      pix_q   <= pix_d;
      frm_q   <= frm_d;
      lin_q   <= lin_d;
    end
  end

  // Source next state: emit the pixel at (x,y), then advance the raster.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    b_d      = b_q;
    pix_d    = 8'h00;
    frm_d    = 1'b0;
    lin_d    = 1'b0;
    row_done = 1'b0;
    unique case (state_q)
      ACTIVE: begin
        pix_d = (x_q == y_q) ? 8'hFF : 8'h00;
        lin_d = (x_q == 8'd0);
        frm_d = (x_q == 8'd0) && (y_q == 8'd0);
        if (x_q == XMAX) begin
          x_d = '0;
          b_d = '0;
          if (HB_EN) state_d = HBLANK;
          else       row_done = 1'b1;
        end else begin
          x_d = x_q + 8'd1;
        end
      end
      HBLANK: begin
        if (b_q == HMAX) begin
          b_d      = '0;
          row_done = 1'b1;
        end else begin
          b_d = b_q + 16'd1;
        end
      end
      VBLANK: begin
        if (b_q == VMAX) begin
          b_d     = '0;
          y_d     = '0;
          state_d = ACTIVE;
        end else begin
          b_d = b_q + 16'd1;
        end
      end
      default: begin
        state_d = ACTIVE;
        x_d     = '0;
        y_d     = '0;
        b_d     = '0;
      end
    endcase
    if (row_done) begin
      if (y_q != YMAX) begin
        y_d     = y_q + 8'd1;
        state_d = ACTIVE;
      end else if (VB_EN) begin
        state_d = VBLANK;
      end else begin
        y_d     = '0;
        state_d = ACTIVE;
      end
    end
  end

  // Sink registers: captured pixel and its coordinates.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      data_q <= '0;
      i_q    <= '0;
      j_q    <= '0;
      col_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      i_q    <= i_d;
      j_q    <= j_d;
      col_q  <= col_d;
    end
  end

  // Sink next state: Frame wins over Line; column count stops at WIDTH.
  always_comb begin
    data_d = data_q;
    i_d    = i_q;
    j_d    = j_q;
    col_d  = col_q;
    if (frm_q) begin
      i_d    = '0;
      j_d    = '0;
      data_d = pix_q;
      col_d  = COL_EN;
    end else if (lin_q) begin
      i_d    = '0;
      j_d    = j_q + 8'd1;
      data_d = pix_q;
      col_d  = COL_EN;
    end else if (col_q) begin
      i_d    = i_q + 8'd1;
      data_d = pix_q;
      col_d  = (i_q != XLAST);
    end
  end

  assign Pixel = pix_q;
  assign Frame = frm_q;
  assign Line  = lin_q;
  assign data  = data_q;
  assign i     = i_q;
  assign j     = j_q;

endmodule

// File: tb/tb_in_out_handle.sv
// Directed bench for in_out_handle: default raster plus a small
// 4x2 no-blank instance, with table vectors and reset corner cases.
module tb_in_out_handle;

  logic       clk;
  logic       rst_n;
  logic [7:0] pix, dat, ii, jj;
  logic       frm, lin;
  logic [7:0] s_pix, s_dat, s_ii, s_jj;
  logic       s_frm, s_lin;

  int n_chk  = 0;
  int n_fail = 0;

  in_out_handle u_dut (
    .Clk(clk), .nReset(rst_n),
    .Pixel(pix), .Frame(frm), .Line(lin),
    .data(dat), .i(ii), .j(jj)
  );

  in_out_handle #(
    .WIDTH(4), .HEIGHT(2), .H_BLANK(0), .V_BLANK(0)
  ) u_small (
    .Clk(clk), .nReset(rst_n),
    .Pixel(s_pix), .Frame(s_frm), .Line(s_lin),
    .data(s_dat), .i(s_ii), .j(s_jj)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         k;
    logic [7:0] pix;
    logic       frm;
    logic       lin;
    logic [7:0] dat;
    logic [7:0] ii;
    logic [7:0] jj;
  } vec_t;

  vec_t vec [16];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_vec(input vec_t v);
    string s;
    s = $sformatf("k%0d", v.k);
    chk({s, " Pixel"}, pix, v.pix);
    chk({s, " Frame"}, frm, v.frm);
    chk({s, " Line"},  lin, v.lin);
    chk({s, " data"},  dat, v.dat);
    chk({s, " i"},     ii,  v.ii);
    chk({s, " j"},     jj,  v.jj);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " Pixel"}, pix, 0);
    chk({nm, " Frame"}, frm, 0);
    chk({nm, " Line"},  lin, 0);
    chk({nm, " data"},  dat, 0);
    chk({nm, " i"},     ii,  0);
    chk({nm, " j"},     jj,  0);
    chk({nm, " s_Pixel"}, s_pix, 0);
    chk({nm, " s_i"},     s_ii,  0);
  endtask

  initial begin
    int last_line, last_frame, nlines;
    int t, st;

    //        k    Pix    F  L  data   i      j
    vec[0]  = '{1,   8'hFF, 1, 1, 8'h00, 8'd0,  8'd0};
    vec[1]  = '{2,   8'h00, 0, 0, 8'hFF, 8'd0,  8'd0};
    vec[2]  = '{3,   8'h00, 0, 0, 8'h00, 8'd1,  8'd0};
    vec[3]  = '{17,  8'h00, 0, 0, 8'h00, 8'd15, 8'd0};
    vec[4]  = '{18,  8'h00, 0, 0, 8'h00, 8'd15, 8'd0};
    vec[5]  = '{19,  8'h00, 0, 1, 8'h00, 8'd15, 8'd0};
    vec[6]  = '{20,  8'hFF, 0, 0, 8'h00, 8'd0,  8'd1};
    vec[7]  = '{21,  8'h00, 0, 0, 8'hFF, 8'd1,  8'd1};
    vec[8]  = '{96,  8'hFF, 0, 0, 8'h00, 8'd4,  8'd5};
    vec[9]  = '{97,  8'h00, 0, 0, 8'hFF, 8'd5,  8'd5};
    vec[10] = '{98,  8'h00, 0, 0, 8'h00, 8'd6,  8'd5};
    vec[11] = '{286, 8'hFF, 0, 0, 8'h00, 8'd14, 8'd15};
    vec[12] = '{287, 8'h00, 0, 0, 8'hFF, 8'd15, 8'd15};
    vec[13] = '{289, 8'h00, 0, 0, 8'hFF, 8'd15, 8'd15};
    vec[14] = '{293, 8'hFF, 1, 1, 8'hFF, 8'd15, 8'd15};
    vec[15] = '{294, 8'h00, 0, 0, 8'hFF, 8'd0,  8'd0};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    last_line  = -1;
    last_frame = -1;
    nlines     = 0;
    for (int k = 1; k <= 600; k++) begin
      @(posedge clk);
      #1;
      foreach (vec[v]) if (vec[v].k == k) chk_vec(vec[v]);
      if (k >= 2) begin
        chk($sformatf("k%0d diag", k), dat,
            (ii == jj) ? 8'hFF : 8'h00);
      end
      if (frm) begin
        if (last_frame >= 0) begin
          chk("frame spacing", k - last_frame, 292);
          chk("lines per frame", nlines, 16);
        end
        last_frame = k;
        nlines     = 0;
      end
      if (lin) begin
        if (!frm && last_line >= 0)
          chk("line spacing", k - last_line, 18);
        last_line = k;
        nlines++;
      end
      if (k <= 24) begin
        t = (k - 1) % 8;
        chk($sformatf("s k%0d Frame", k), s_frm, t == 0);
        chk($sformatf("s k%0d Line", k), s_lin, (t % 4) == 0);
        chk($sformatf("s k%0d Pixel", k), s_pix,
            (t == 0 || t == 5) ? 8'hFF : 8'h00);
        if (k >= 2) begin
          st = (k - 2) % 8;
          chk($sformatf("s k%0d i", k), s_ii, st % 4);
          chk($sformatf("s k%0d j", k), s_jj, st / 4);
          chk($sformatf("s k%0d data", k), s_dat,
              (st == 0 || st == 5) ? 8'hFF : 8'h00);
        end
      end
    end

    // Mid-frame abort: source emits row 7 column 3 on edge k=130.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 130; k++) begin
      @(posedge clk);
      #1;
    end
    chk("r7c3 Pixel", pix, 8'h00);
    chk("r7c3 i", ii, 8'd2);
    chk("r7c3 j", jj, 8'd7);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("abort");
    @(posedge clk);
    #1;
    chk_zero("abort held");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("restart Frame", frm, 1);
    chk("restart Line", lin, 1);
    chk("restart Pixel", pix, 8'hFF);
    @(posedge clk);
    #1;
    chk("restart data", dat, 8'hFF);
    chk("restart i", ii, 0);
    chk("restart j", jj, 0);
    chk("restart s_i", s_ii, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
